nbit_serial_comparator: RTL
===========================

# nbit_serial_comparator

Parametrised, multi-cycle magnitude comparator: a WIDTH-bit generalisation of the combinational greater/equal/less comparators in the Digital Circuits collection. It latches two operands on a start handshake and scans them MSB-first, DIGIT bits per clock. It produces registered one-hot g/e/s flags with a done pulse, and supports unsigned and two's-complement compares. It sits wherever a wide compare must be traded for area or timing.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 2 and a multiple of DIGIT.
- DIGIT, 2, bits examined per compare cycle; N = WIDTH/DIGIT slices.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- start  input  1  request; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- signed_mode  input  1  1 = two's complement, 0 = unsigned; sampled with a/b.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: the result is valid.
- g  output  1  A > B.
- e  output  1  A == B.
- s  output  1  A < B.

## Operation
- States:
  - IDLE: reset state.
  - RUN: compare in progress.
  - DONE: one cycle.
- IDLE/DONE + start=1:
  - Latch a, b and signed_mode.
  - Set slice index idx = N-1.
  - Clear g/e/s to 0.
  - Go to RUN.
- DONE + start=0 → IDLE.
- Signed mode: invert bit WIDTH-1 of both latched operands, then compare unsigned. The result is identical to a signed compare.
- RUN, each edge: compare slice idx, i.e. bits [idx*DIGIT+DIGIT-1 : idx*DIGIT].
  - Slice A > slice B, no earlier difference: decided g.
  - Slice A < slice B, no earlier difference: decided s.
  - Once decided, the result is sticky; later slices do not change it.
- Termination (see Configuration):
  - On termination, register exactly one of g/e/s.
  - e=1 only if every slice is equal.
  - Go to DONE.
- Otherwise, decrement idx.
- start while in RUN is ignored: no re-latch and no effect on the result.
- g/e/s hold their value from DONE through IDLE until the next accepted start.
- Reset at any time (including mid-RUN):
  - Go to IDLE.
  - idx = 0.
  - busy = done = g = e = s = 0.
  - The in-flight compare is discarded.

## Timing
- Reset values: busy 0, done 0, g 0, e 0, s 0, state IDLE.
- Accepting edge = T0.
  - busy is high from T0 until the terminating edge.
  - done and g/e/s are visible after the terminating edge, Tk.
- Full scan latency: k = N edges.
- Early-exit latency: k = position, counted from the MSB, of the first differing slice (1..N); N if the operands are equal.
- done is high for exactly one cycle, coinciding with DONE.
- start during DONE:
  - Accepted at that edge; done falls.
  - busy rises.
  - g/e/s clear.
  - No IDLE cycle between operations.
- Throughput: one compare per k+1 cycles worst case; back-to-back restart from DONE gives k+1.

## Configuration
- CMP_EARLY_EXIT_EN defined: RUN terminates on the first differing slice, giving data-dependent latency.
- CMP_EARLY_EXIT_EN undefined:
  - RUN always runs N edges and terminates at idx==0.
  - The sticky decision preserves the first difference.
  - Latency is a constant N.
- Results are identical in both builds; only timing differs.

## Test plan
Test configuration: WIDTH=8, DIGIT=2, N=4.
- Equal operands: unsigned, a=0xA5, b=0xA5, start 1 cycle → done after 4 edges; e=1, g=s=0; busy high for 4 cycles.
- MSB difference: unsigned, a=0x80, b=0x7F → g=1. done after 1 edge with CMP_EARLY_EXIT_EN, after 4 edges without.
- Signed compare: signed_mode=1, a=0x80 (-128), b=0x7F (+127) → s=1. Repeat with signed_mode=0 → g=1.
- LSB difference: a=0x34, b=0x35 → s=1, done after 4 edges in both builds. Toggle a/b and start during RUN → result unchanged and no restart.
- Reset mid-RUN: assert rst_n=0 at edge 2 of a compare → all outputs 0 immediately (asynchronous). After release, IDLE; a new start then completes normally.
- Back-to-back: start held high during DONE with new a=0x10, b=0x20 → done falls; busy rises the same edge; g/e/s clear; second result s=1 with correct latency.

Source files
------------

// File: rtl/nbit_serial_comparator.sv
// nbit_serial_comparator
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are latched on an
// accepted start and scanned MSB-first, DIGIT bits per clock. The result is
// a registered one-hot g/e/s triple, qualified by a one-cycle done pulse.
// Unsigned and two's-complement compares are both supported.
//
// Parameters
//   WIDTH  operand width (>= 2, multiple of DIGIT)
//   DIGIT  bits examined per compare cycle; N = WIDTH/DIGIT slices
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, accepted in IDLE or DONE
//   a, b         operands, sampled on the accepting edge
//   signed_mode  1 = two's complement, 0 = unsigned (sampled with a/b)
//   busy         high while the scan is running
//   done         one-cycle pulse, result valid
//   g / e / s    A > B / A == B / A < B, held until the next accepted start
//
// Build option
//   CMP_EARLY_EXIT_EN  when defined, the scan stops at the first differing
//                      slice; otherwise it always runs N cycles. Results are
//                      the same in both builds, only latency differs.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | reset state, waiting for start
// RUN   | scanning one slice per clock, MSB slice first
// DONE  | result valid for one cycle, done asserted

module nbit_serial_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             s
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = '0;
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  // sticky "a difference has been seen" flags for the running scan
  logic             gt_q, gt_nxt;
  logic             lt_q, lt_nxt;
  logic             g_nxt, e_nxt, s_nxt;

  logic [DIGIT-1:0] slice_a, slice_b;
  logic             dec_gt, dec_lt, term;

  assign slice_a = a_q[idx*DIGIT +: DIGIT];
  assign slice_b = b_q[idx*DIGIT +: DIGIT];

  // The first difference wins; the other flag can only be set while neither
  // has been seen yet, so the pair never holds 2'b11.
  assign dec_gt = gt_q | (~lt_q & (slice_a > slice_b));
  assign dec_lt = lt_q | (~gt_q & (slice_a < slice_b));

`ifdef CMP_EARLY_EXIT_EN
  assign term = (idx == IDX_ZERO) | dec_gt | dec_lt;
`else
  assign term = (idx == IDX_ZERO);
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      g     <= 1'b0;
      e     <= 1'b0;
      s     <= 1'b0;
    end else begin
      state <= state_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      idx   <= idx_nxt;
      gt_q  <= gt_nxt;
      lt_q  <= lt_nxt;
      g     <= g_nxt;
      e     <= e_nxt;
      s     <= s_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    idx_nxt   = idx;
    gt_nxt    = gt_q;
    lt_nxt    = lt_q;
    g_nxt     = g;
    e_nxt     = e;
    s_nxt     = s;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          // Flipping both sign bits maps two's complement order onto
          // unsigned order, so the scan itself is always unsigned.
          a_nxt     = a ^ (signed_mode ? SIGN_MASK : '0);
          b_nxt     = b ^ (signed_mode ? SIGN_MASK : '0);
          idx_nxt   = IDX_TOP;
          gt_nxt    = 1'b0;
          lt_nxt    = 1'b0;
          g_nxt     = 1'b0;
          e_nxt     = 1'b0;
          s_nxt     = 1'b0;
          state_nxt = RUN;
        end else if (state == DONE) begin
          state_nxt = IDLE;
        end
      end

      RUN: begin
        gt_nxt = dec_gt;
        lt_nxt = dec_lt;
        if (term) begin
          g_nxt     = dec_gt;
          s_nxt     = dec_lt;
          e_nxt     = ~dec_gt & ~dec_lt;
          state_nxt = DONE;
        end else begin
          idx_nxt = idx - IDX_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
